// File: rtl/display_formatter_pkg.sv
// Shared definitions for the display formatter.
// Contents:
//   - active-low 7-segment codes in {dp,g,f,e,d,c,b,a} order
//   - the displayable value range
//   - the conversion FSM state type
package display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Four digits available: up to 9999, or a minus sign plus three digits.
    localparam int MAX_DISP = 9999;
    localparam int MIN_DISP = -999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABS    = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_ENCODE = 2'd3
    } fmt_state_t;

endpackage

// File: rtl/display_formatter_bcd_to_seg.sv
// Combinational decoder from one BCD digit to an active-low 7-segment
// pattern.
// Ports:
//   bcd - 4-bit BCD digit
//   seg - {dp,g,f,e,d,c,b,a} pattern, 0 = lit; dp is always off
// Codes 10..15 never reach this decoder; they decode to blank.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Digit lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_formatter.sv
// Converts a signed binary result into four active-low 7-segment patterns.
// The conversion is iterative: take the absolute value, then run a 14-cycle
// shift-add-3 (double-dabble) conversion, then encode. Leading zeros are
// blanked, a minus sign is placed next to the leading digit, and
// out-of-range values show "Err".
// Ports:
//   clk_out        - clock
//   rst            - asynchronous active-high reset
//   load           - single-cycle convert request, honoured only when idle
//   value          - two's-complement value, sampled at the accepted load
//   busy           - conversion in progress
//   done           - one-cycle pulse, digits updated this cycle
//   err            - last converted value was out of range
//   digit3..digit0 - segment patterns, digit0 is the rightmost digit
module display_formatter
    import display_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int MAG_W = 14
) (
    input  logic            clk_out,
    input  logic            rst,
    input  logic            load,
    input  logic [IN_W-1:0] value,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      digit0,
    output logic [7:0]      digit1,
    output logic [7:0]      digit2,
    output logic [7:0]      digit3
);

    localparam logic signed [IN_W-1:0] MAX_V    = IN_W'(MAX_DISP);
    localparam logic signed [IN_W-1:0] MIN_V    = IN_W'(MIN_DISP);
    localparam logic [3:0]             CNT_INIT = 4'(MAG_W - 1);

    fmt_state_t       state_r;
    fmt_state_t       next_state_s;
    logic             accept_s;
    logic             encode_s;

    logic [IN_W-1:0]  value_r;
    logic             neg_r;
    logic             range_err_r;
    logic [MAG_W-1:0] mag_r;
    logic [15:0]      bcd_r;
    logic [3:0]       cnt_r;

    logic [IN_W-1:0]  abs_s;
    logic             range_s;
    logic [15:0]      bcd_adj_s;
    logic [3:0]       nz_s;
    logic [1:0]       msd_s;
    logic [7:0]       seg_s [4];
    logic [7:0]       enc_s [4];

    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [7:0]       digit0_r;
    logic [7:0]       digit1_r;
    logic [7:0]       digit2_r;
    logic [7:0]       digit3_r;

    // State register.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    next_state_s = ST_ABS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ABS:    next_state_s = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_ENCODE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_ENCODE: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // FSM strobes: accept a load when idle; publish the digits when encoding.
    always_comb begin
        accept_s = 1'b0;
        encode_s = 1'b0;
        case (state_r)
            ST_IDLE:   accept_s = load;
            ST_ENCODE: encode_s = 1'b1;
            default: begin
                accept_s = 1'b0;
                encode_s = 1'b0;
            end
        endcase
    end

    // Absolute value in full input width. -2^(IN_W-1) wraps to itself, but
    // the range check flags that value first.
    always_comb begin
        if (value_r[IN_W-1]) begin
            abs_s = ~value_r + {{(IN_W-1){1'b0}}, 1'b1};
        end else begin
            abs_s = value_r;
        end
        range_s = ($signed(value_r) > MAX_V) || ($signed(value_r) < MIN_V);
    end

    // Double-dabble step: add 3 to every BCD nibble of 5 or more before the
    // shift.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < 4; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
    end

    // Conversion datapath: capture, absolute value, then shift.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            value_r     <= '0;
            neg_r       <= 1'b0;
            range_err_r <= 1'b0;
            mag_r       <= '0;
            bcd_r       <= 16'h0000;
            cnt_r       <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        value_r <= value;
                    end
                end
                ST_ABS: begin
                    range_err_r <= range_s;
                    neg_r       <= value_r[IN_W-1];
                    mag_r       <= abs_s[MAG_W-1:0];
                    bcd_r       <= 16'h0000;
                    cnt_r       <= CNT_INIT;
                end
                ST_SHIFT: begin
                    bcd_r <= {bcd_adj_s[14:0], mag_r[MAG_W-1]};
                    mag_r <= {mag_r[MAG_W-2:0], 1'b0};
                    cnt_r <= cnt_r - 4'd1;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // One segment decoder per BCD nibble.
    for (genvar g = 0; g < 4; g++) begin : g_seg
        bcd_to_seg u_bcd_to_seg (
            .bcd (bcd_r[4*g +: 4]),
            .seg (seg_s[g])
        );
    end

    // Final encoding. msd_s is the most significant non-zero digit, or 0 when
    // the value is zero so a single "0" is shown. Digits left of it are
    // blanked, and the one immediately left of it takes the minus sign.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nz_s[i] = |bcd_r[4*i +: 4];
        end
        if (nz_s[3]) begin
            msd_s = 2'd3;
        end else if (nz_s[2]) begin
            msd_s = 2'd2;
        end else if (nz_s[1]) begin
            msd_s = 2'd1;
        end else begin
            msd_s = 2'd0;
        end
        for (int i = 0; i < 4; i++) begin
            if (3'(i) <= {1'b0, msd_s}) begin
                enc_s[i] = seg_s[i];
            end else if (neg_r && (3'(i) == ({1'b0, msd_s} + 3'd1))) begin
                enc_s[i] = SEG_MINUS;
            end else begin
                enc_s[i] = SEG_BLANK;
            end
        end
        if (range_err_r) begin
            enc_s[3] = SEG_E;
            enc_s[2] = SEG_R;
            enc_s[1] = SEG_R;
            enc_s[0] = SEG_BLANK;
        end else begin
            enc_s[3] = enc_s[3];
        end
    end

    // Registered outputs. The digits and err change only on the encode edge.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            digit0_r <= SEG_BLANK;
            digit1_r <= SEG_BLANK;
            digit2_r <= SEG_BLANK;
            digit3_r <= SEG_BLANK;
        end else begin
            done_r <= encode_s;
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (encode_s) begin
                busy_r <= 1'b0;
            end
            if (encode_s) begin
                err_r    <= range_err_r;
                digit0_r <= enc_s[0];
                digit1_r <= enc_s[1];
                digit2_r <= enc_s[2];
                digit3_r <= enc_s[3];
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign digit0 = digit0_r;
    assign digit1 = digit1_r;
    assign digit2 = digit2_r;
    assign digit3 = digit3_r;

endmodule

// File: tb/tb_display_formatter.sv
// Self-checking bench for display_formatter: directed cases plus
// randomized values, compared against a decimal-arithmetic reference model.
module tb_display_formatter;

    logic        clk_out = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  digit0;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  digit3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_disp;
    logic        exp_err;

    display_formatter dut (
        .clk_out (clk_out),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .digit0  (digit0),
        .digit1  (digit1),
        .digit2  (digit2),
        .digit3  (digit3)
    );

    always #5 clk_out = ~clk_out;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic out_of_range(input int v);
        return (v > 9999) || (v < -999);
    endfunction

    // Reference model: decimal digits of |v| right-aligned, minus just left
    // of them, everything else blank; "Err" when out of range.
    function automatic logic [31:0] model_disp(input int v);
        logic [7:0]  tbl [10];
        logic [31:0] d;
        int          m;
        int          ndig;
        int          t;
        int          pw;
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (out_of_range(v)) return {8'h86, 8'hAF, 8'hAF, 8'hFF};
        m    = (v < 0) ? -v : v;
        ndig = 1;
        t    = m / 10;
        while (t > 0) begin
            ndig++;
            t = t / 10;
        end
        d  = 32'hFFFF_FFFF;
        pw = 1;
        for (int p = 0; p < 4; p++) begin
            if (p < ndig) d[p*8 +: 8] = tbl[(m / pw) % 10];
            else if (v < 0 && p == ndig) d[p*8 +: 8] = 8'hBF;
            pw = pw * 10;
        end
        return d;
    endfunction

    function automatic logic [31:0] disp_now();
        return {digit3, digit2, digit1, digit0};
    endfunction

    // Drive load for one edge (edge k) and confirm busy rises.
    task automatic start_load(input int v);
        load  = 1'b1;
        value = v[15:0];
        @(posedge clk_out);
        #1;
        load  = 1'b0;
        value = 16'($urandom);
        check_val("busy_at_k", {busy, done, disp_now()}, {1'b1, 1'b0, exp_disp});
    endtask

    // Follow edges k+1..k+16; optionally pulse load with 77 at edge k+inj_at.
    task automatic finish_conv(input int v, input int inj_at, input string tag);
        for (int c = 1; c <= 16; c++) begin
            if (c == inj_at) begin
                load  = 1'b1;
                value = 16'd77;
            end
            @(posedge clk_out);
            #1;
            load = 1'b0;
            if (c < 16) begin
                check_val({tag, "_busy"}, {busy, done, disp_now()}, {1'b1, 1'b0, exp_disp});
            end else begin
                exp_disp = model_disp(v);
                exp_err  = out_of_range(v);
                check_val({tag, "_done"}, {busy, done, err}, {1'b0, 1'b1, exp_err});
                check_val({tag, "_digits"}, disp_now(), exp_disp);
            end
        end
    endtask

    task automatic hold_check(input string tag);
        @(posedge clk_out);
        #1;
        check_val(tag, {busy, done, err, disp_now()}, {1'b0, 1'b0, exp_err, exp_disp});
    endtask

    task automatic convert(input int v, input string tag);
        start_load(v);
        finish_conv(v, 0, tag);
        hold_check({tag, "_hold"});
    endtask

    initial begin
        int dirs [9];
        int v;
        logic [15:0] r;

        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0000;
        exp_disp = 32'hFFFF_FFFF;
        exp_err  = 1'b0;
        #1;
        check_val("reset_init", {busy, done, err, disp_now()}, {3'b000, 32'hFFFF_FFFF});
        repeat (2) @(posedge clk_out);
        #1;
        rst = 1'b0;

        dirs = '{1234, -5, -999, 0, 9999, 10000, -1000, -32768, 7};
        foreach (dirs[i]) begin
            convert(dirs[i], $sformatf("dir%0d", dirs[i]));
        end

        // Load ignored while busy; load coincident with done accepted.
        start_load(42);
        finish_conv(42, 5, "hs42");
        start_load(77);
        finish_conv(77, 0, "hs77");
        hold_check("hs77_hold");

        // Asynchronous reset with err set and digits showing.
        convert(10000, "pre_rst");
        @(negedge clk_out);
        rst = 1'b1;
        #1;
        exp_disp = 32'hFFFF_FFFF;
        exp_err  = 1'b0;
        check_val("reset_async", {busy, done, err, disp_now()}, {3'b000, exp_disp});
        @(posedge clk_out);
        #1;
        rst = 1'b0;

        // Reset in the middle of a conversion aborts it.
        convert(1234, "pre_abort");
        start_load(500);
        repeat (7) begin
            @(posedge clk_out);
            #1;
        end
        rst = 1'b1;
        #1;
        exp_disp = 32'hFFFF_FFFF;
        exp_err  = 1'b0;
        check_val("abort_rst", {busy, done, err, disp_now()}, {3'b000, exp_disp});
        @(posedge clk_out);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_out);
            #1;
            check_val("abort_idle", {busy, done, err, disp_now()}, {3'b000, exp_disp});
        end
        convert(3, "after_abort");

        // Randomized values, mostly in range with some full-width values.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 16'($urandom);
                v = int'($signed(r));
            end else begin
                v = int'($urandom_range(0, 10998)) - 999;
            end
            convert(v, $sformatf("rnd%0d", v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_formatter.md
Name: display_formatter

Overview:
- Converts a signed binary result from the calculator datapath into four 7-segment patterns (digit3..digit0) for the display digit multiplexer.
- Uses iterative shift-add-3 (double-dabble) BCD conversion, leading-zero blanking, minus-sign placement and "Err" indication.
- digit0 is the rightmost, least-significant digit. Segment outputs are held stable between conversions.

Parameters:
- IN_W, 16, width of the two's-complement input value.
- MAG_W, 14, magnitude bits shifted through the double-dabble; fixed by the 9999 maximum.

Ports:
- clk_out  input  1  block clock
- rst  input  1  reset, asynchronous, active-high
- load  input  1  single-cycle request to convert value
- value  input  IN_W  signed two's-complement number to display
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse; digits updated this cycle
- err  output  1  last converted value was out of range
- digit0  output  8  rightmost segment pattern
- digit1  output  8  segment pattern
- digit2  output  8  segment pattern
- digit3  output  8  leftmost segment pattern

Behaviour:
- Segment format: {dp,g,f,e,d,c,b,a}, active-low (0 = lit). dp is always off (bit7 = 1).
- Segment codes:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - minus=BF, E=86, r=AF, blank=FF
- Reset (async, any state): state=IDLE; digit0..3=FF; busy=0; done=0; err=0; internal registers cleared. An in-flight conversion is aborted and produces no done.
- States: IDLE -> ABS -> SHIFT -> ENCODE -> IDLE.
- Cycle timing, with load sampled high in IDLE at edge k:
  - Edge k: capture value; busy=1; go to ABS.
  - Edge k+1 (ABS):
    - range flag = (value > 9999) or (value < -999);
    - neg = value[IN_W-1];
    - mag = |value| truncated to MAG_W bits (don't-care when out of range);
    - clear BCD accumulator; counter = MAG_W-1.
  - Edges k+2..k+15 (SHIFT, 14 cycles): each cycle add 3 to every BCD nibble >= 5, then shift {bcd, mag} left 1. Leave SHIFT when counter hits 0.
  - Edge k+16 (ENCODE): register all four digits and err together; done=1 for exactly this one cycle; busy=0; return to IDLE.
- Latency is a fixed 16 cycles from the load edge to the digit update, for every input including out-of-range.
- Digits never show intermediate values; outputs change only at the ENCODE edge.
- Encoding in range:
  - Blank leading zeros. Value 0 shows blank,blank,blank,"0".
  - Negative: minus occupies the digit immediately left of the most significant non-zero digit. -7 -> FF,FF,BF,F8; -999 -> BF,90,90,90.
- Encoding out of range: digit3..0 = E,r,r,blank (86,AF,AF,FF); err=1.
- err holds its value until the next ENCODE or reset.
- load while busy (ABS/SHIFT/ENCODE) is ignored, with no queuing.
- load in the same cycle as done is accepted: FSM is already IDLE at that edge.
- value is sampled only at the accepted load edge. Later changes have no effect.
- Width rules:
  - 4-nibble BCD accumulator (16 bits). No fifth digit is needed because range is checked first.
  - Abs value computed in IN_W bits. -2^(IN_W-1) is caught by the range check.

Decomposition:
- Shared package (display_pkg):
  - segment code constants (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_R, SEG_BLANK);
  - state enum for the FSM;
  - MAX_DISP=9999, MIN_DISP=-999.
- One combinational sub-module, bcd_to_seg: 4-bit BCD in, 8-bit active-low pattern out. Instantiated four times in the ENCODE path.
- Sequencing, blanking and sign placement stay in display_formatter.

Test Plan:
1. Reset:
   - Stimulus: assert rst mid-simulation.
   - Required: immediately (no clock edge) digit0..3=FF, busy=0, done=0, err=0.
2. Positive conversion and latency:
   - Stimulus: load with value=1234.
   - Required: busy high edges k..k+15; done pulse exactly after edge k+16; digit3..0=F9,A4,B0,99; err=0.
3. Negative values and zero:
   - Stimulus: load -5, then -999, then 0.
   - Required: -5 -> FF,FF,BF,92; -999 -> BF,90,90,90; 0 -> FF,FF,FF,C0.
4. Range boundaries:
   - Stimulus: load 9999, 10000, -1000, -32768.
   - Required: 9999 -> 90,90,90,90 with err=0; each of the others -> 86,AF,AF,FF with err=1, each done after 16 cycles.
5. Handshake:
   - Stimulus: load 42; pulse load with 77 at cycle k+5; then load 77 coincident with done.
   - Required: the mid-conversion 77 is ignored (display FF,FF,99,A4); the second 77 is accepted (display FF,FF,F8,F8 16 cycles later).
6. Reset mid-conversion:
   - Stimulus: load 500; assert rst at cycle k+8; release rst.
   - Required: digits blank, no done pulse, FSM IDLE; a following load of 3 converts normally to FF,FF,FF,B0.
